// File: rtl/serial_txq_mem.sv
// Byte storage for the transmit queue: a register array with synchronous
// write and combinational read, so the head byte is visible in the same cycle.
module serial_txq_mem #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk12,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [7:0]            rdata
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [7:0] mem [DEPTH];

  // Contents are never reset; only pointers decide which entries are valid.
  always_ff @(posedge clk12) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/serial_txq.sv
// Transmit byte queue feeding the serial transmitter: circular FIFO with an
// explicit level counter, head byte presented combinationally, sticky overflow.
module serial_txq #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk12,
  input  logic                  reset,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [7:0]            sbyte,
  output logic                  sbyte_rdy,
  input  logic                  ack,
  output logic                  empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LEVEL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  // Status flags decode only the registered level, never wr_en or ack.
  assign sbyte_rdy = (level != '0);
  assign empty     = (level == '0);
  assign full      = (level == LEVEL_MAX);

  // A pop frees the slot in the same edge, so a write into a full queue is
  // accepted when the head leaves at the same time.
  assign pop  = ack & sbyte_rdy;
  assign push = wr_en & (~full | pop);

  always_ff @(posedge clk12) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        level <= level + LEVEL_ONE;
      end else if (pop && !push) begin
        level <= level - LEVEL_ONE;
      end
      // A dropped byte wins over a clear requested in the same cycle.
      if (wr_en && full && !pop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  serial_txq_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk12 (clk12),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (sbyte)
  );

endmodule

// File: doc/serial_txq.md
Name: serial_txq

Overview:
Transmit byte queue directly upstream of the serial transmitter. It accepts bytes from any producer at up to one per clk12 cycle and buffers them in a circular FIFO. It presents the head byte on sbyte/sbyte_rdy and pops it on the transmitter's ack, so bursts are serialised back-to-back without producer stalls. It also reports fill level and keeps a sticky overflow flag for debug.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries (16 by default); legal range 1..10.

Ports:
clk12  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
wr_data  input  8  byte to enqueue.
wr_en  input  1  enqueue strobe, one byte per cycle while high.
full  output  1  high when level == depth.
level  output  DEPTH_LOG2+1  current number of stored bytes, 0..depth.
overflow  output  1  sticky; set when wr_en is high while full and no pop occurs that cycle.
ovf_clr  input  1  clears overflow.
sbyte  output  8  head-of-queue byte, to transmitter.
sbyte_rdy  output  1  head valid, i.e. level != 0.
ack  input  1  from transmitter; pop the head this cycle (combinational in transmitter: sbyte_rdy & ~busy).
empty  output  1  level == 0.

Behaviour:
- Storage: register array of depth × 8; wr_ptr and rd_ptr are DEPTH_LOG2 bits wide and wrap modulo depth; level is an explicit counter.
- Reset (synchronous, reset=1 at a clk12 edge): wr_ptr=0, rd_ptr=0, level=0, overflow=0. Consequently full=0, empty=1, sbyte_rdy=0. Array contents are not reset; sbyte is don't-care while sbyte_rdy=0.
- Reset mid-operation: pending bytes are discarded and ack is ignored during reset. The transmitter may finish a byte already loaded; the queue does not track that.
- sbyte = mem[rd_ptr], a combinational read of the register array, so it is valid in the same cycle sbyte_rdy is high. This is required because the transmitter samples sbyte in the same cycle ack asserts.
- sbyte_rdy, empty, full: combinational decodes of registered level only, with no combinational path from wr_en or ack.
- Push: when wr_en=1 and (level<depth or pop), write mem[wr_ptr]<=wr_data and increment wr_ptr.
- Pop: pop = ack & sbyte_rdy. When pop, increment rd_ptr. ack while empty is ignored and pointers do not move.
- level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a byte written into an empty queue gives sbyte_rdy=1 and sbyte=that byte on the next cycle. Zero-cycle bypass is not provided.
- Full with simultaneous wr_en and pop: the write is accepted; the head leaves and the new byte enters; level stays at depth; overflow is not set.
- Full with wr_en and no pop: the byte is dropped, pointers are unchanged, and overflow<=1 at that edge.
- Empty with wr_en and ack in the same cycle: ack is ignored (sbyte_rdy=0); the push is accepted and level becomes 1.
- Overflow priority at a single edge: reset > overflow set > ovf_clr. A set event in the same cycle as ovf_clr leaves overflow=1.
- Throughput: with the transmitter at 11 cycles/byte, sustained input above 1 byte/11 cycles eventually fills the queue. Producers must gate on full; overflow exists for detection only.

Decomposition:
- No shared package needed. Depth is derived locally from DEPTH_LOG2 as a localparam.
- One natural sub-module, serial_txq_mem: an 8-bit register array with synchronous write and combinational read, parameterised by DEPTH_LOG2.
- Pointer, level and flag logic stay in serial_txq.

Test Plan:
1. Reset, then write 0x41 in one cycle with ack tied 0 -> next cycle sbyte_rdy=1, sbyte=0x41, level=1, empty=0.
2. Burst write 0x30..0x33 on 4 consecutive cycles with ack = sbyte_rdy & ~busy from a transmitter model -> bytes are popped in order 0x30,0x31,0x32,0x33 at 11-cycle spacing; level returns to 0 and sbyte_rdy=0 after the last pop.
3. Write 16 bytes (DEPTH_LOG2=4) with ack=0, then a 17th 0xEE -> full=1, level=16, overflow=1; 0xEE is never output. Drain -> output is the original 16 bytes. Pulse ovf_clr -> overflow=0.
4. Fill to 16, then drive wr_en=1 (0x55) and ack=1 in the same cycle -> level stays 16, overflow=0, old head is popped, 0x55 is output last after draining.
5. Queue empty, wr_en=1 (0x7A) and ack=1 in the same cycle -> no pop, level=1, next-cycle sbyte=0x7A.
6. Hold 5 bytes queued, assert reset for one cycle during a transmission -> level=0, sbyte_rdy=0, overflow=0 on the following cycle. The next write of 0x01 appears as the head one cycle later, confirming pointer wrap from 0.
